// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM encoding, datapath width and index-width helper for the GCD scheduler.
package gcd_pkg;

  localparam int GCD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP,
    COOL
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first active request after last_grant, wrapping at NREQ-1.
module rr_arbiter
  import gcd_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_scheduler.sv
// gcd_scheduler: shares one GCD engine among NREQ requesters with round-robin arbitration.
// Define GCD_SCHED_TIMEOUT_EN to add the BUSY watchdog that resets a stuck engine.
//
// state | meaning
// IDLE  | arbitrate, accept one request and capture its operands
// ISSUE | pulse eng_start, or bypass the engine when an operand is zero
// BUSY  | hold operands on the engine until eng_done (or watchdog expiry)
// RESP  | result is registered toward the owning requester
// COOL  | wait for eng_done to drop before the next grant
module gcd_scheduler
  import gcd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [GCD_W*NREQ-1:0] req_a,
  input  logic [GCD_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [GCD_W-1:0]      rsp_gcd,
  output logic                  rsp_err,
  output logic                  eng_start,
  output logic [GCD_W-1:0]      eng_a,
  output logic [GCD_W-1:0]      eng_b,
  input  logic                  eng_done,
  input  logic [GCD_W-1:0]      eng_gcd,
  output logic                  eng_rst_n
);

  localparam int IDX_W = idx_w(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 2047) begin : g_bad_param
    $error("gcd_scheduler: NREQ must be 2..8 and TIMEOUT 1..2047");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, grant_idx_q, arb_idx;
  logic [NREQ-1:0]    arb_grant;
  logic               arb_any;
  logic [GCD_W-1:0]   op_a_q, op_b_q, result_q;
  logic               accept, bypass, timeout_hit;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  assign accept = (state_q == IDLE) && arb_any;
  assign bypass = (op_a_q == '0) || (op_b_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    eng_start = 1'b0;
    eng_a     = '0;
    eng_b     = '0;
    eng_rst_n = !rst;
    unique case (state_q)
      IDLE: begin
        if (arb_any && !rst) begin
          req_ready = arb_grant;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (bypass) begin
          state_d = RESP;
        end else begin
          eng_start = 1'b1;
          eng_a     = op_a_q;
          eng_b     = op_b_q;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        eng_a = op_a_q;
        eng_b = op_b_q;
        if (eng_done) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          eng_rst_n = 1'b0;
          state_d   = RESP;
        end
      end
      RESP:    state_d = COOL;
      COOL:    if (!eng_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IDX_W'(NREQ - 1);
      grant_idx_q  <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
    end else begin
      if (accept) begin
        last_grant_q <= arb_idx;
        grant_idx_q  <= arb_idx;
        op_a_q       <= req_a[int'(arb_idx)*GCD_W +: GCD_W];
        op_b_q       <= req_b[int'(arb_idx)*GCD_W +: GCD_W];
      end
      // gcd(x,0)=x and gcd(0,0)=0 both reduce to a|b
      if (state_q == ISSUE && bypass) result_q <= op_a_q | op_b_q;
      if (state_q == BUSY) begin
        if (eng_done)         result_q <= eng_gcd;
        else if (timeout_hit) result_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_gcd   <= '0;
    end else if (state_q == RESP) begin
      rsp_valid <= NREQ'(1) << grant_idx_q;
      rsp_gcd   <= result_q;
    end else begin
      rsp_valid <= '0;
      rsp_gcd   <= '0;
    end
  end

`ifdef GCD_SCHED_TIMEOUT_EN
  logic [10:0] busy_cnt_q;
  logic        err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_q <= '0;
      err_q      <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (state_q == ISSUE)     busy_cnt_q <= '0;
      else if (state_q == BUSY) busy_cnt_q <= busy_cnt_q + 11'd1;
      if (accept)               err_q <= 1'b0;
      else if (timeout_hit)     err_q <= 1'b1;
      rsp_err <= (state_q == RESP) && err_q;
    end
  end

  assign timeout_hit = (state_q == BUSY) && !eng_done && (busy_cnt_q == 11'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_scheduler.sv
// tb_gcd_scheduler: directed vector table plus hand-written contention, long-done,
// mid-operation reset and (with GCD_SCHED_TIMEOUT_EN) watchdog sequences.
module tb_gcd_scheduler;

  localparam int NREQ = 4;
`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1023;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [16*NREQ-1:0] req_a = '0;
  logic [16*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [15:0]       rsp_gcd;
  logic              rsp_err;
  logic              eng_start;
  logic [15:0]       eng_a, eng_b;
  logic              eng_done = 1'b0;
  logic [15:0]       eng_gcd = '0;
  logic              eng_rst_n;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  // engine stub controls
  int  lat = 1;
  int  hold = 1;
  bit  never = 1'b0;
  int  e_cnt = 0, h_cnt = 0;
  bit  e_busy = 1'b0;
  logic [15:0] e_res = '0;

  gcd_scheduler #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_gcd   (rsp_gcd),
    .rsp_err   (rsp_err),
    .eng_start (eng_start),
    .eng_a     (eng_a),
    .eng_b     (eng_b),
    .eng_done  (eng_done),
    .eng_gcd   (eng_gcd),
    .eng_rst_n (eng_rst_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // done rises lat+1 cycles after the eng_start cycle and stays high for hold cycles
  always @(posedge clk) begin
    if (!eng_rst_n) begin
      eng_done <= 1'b0;
      eng_gcd  <= '0;
      e_busy   <= 1'b0;
    end else if (eng_start) begin
      if (!never) begin
        e_busy <= 1'b1;
        e_cnt  <= lat - 1;
        e_res  <= gcd16(eng_a, eng_b);
      end
    end else if (e_busy) begin
      if (e_cnt == 0) begin
        e_busy   <= 1'b0;
        eng_done <= 1'b1;
        eng_gcd  <= e_res;
        h_cnt    <= hold - 1;
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end else if (eng_done) begin
      if (h_cnt == 0) begin
        eng_done <= 1'b0;
        eng_gcd  <= '0;
      end else begin
        h_cnt <= h_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
    int          lat;
    int          starts;
    int          latency;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input string tag);
    int n, rdy_c, rsp_c, starts;
    logic [NREQ-1:0] rdy, rv;
    logic [15:0] g, sa, sb;
    logic er;
    rdy_c = 0; rsp_c = 0; starts = 0; rdy = '0; rv = '0; g = '0; sa = '0; sb = '0; er = 1'b0;
    lat = v.lat;
    hold = 1;
    never = 1'b0;
    @(posedge clk); #1;
    req_a[v.idx*16 +: 16] = v.a;
    req_b[v.idx*16 +: 16] = v.b;
    req_valid[v.idx] = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk); n++;
      if (|req_ready) begin rdy = req_ready; rdy_c = cyc; break; end
    end
    @(posedge clk); #1;
    req_valid[v.idx] = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (eng_start) begin starts++; sa = eng_a; sb = eng_b; end
      if (|rsp_valid) begin rv = rsp_valid; g = rsp_gcd; er = rsp_err; rsp_c = cyc; break; end
    end
    @(negedge clk);
    if (eng_start) starts++;
    check({tag, "_ready"}, rdy, NREQ'(1) << v.idx);
    check({tag, "_rsp_valid"}, rv, NREQ'(1) << v.idx);
    check({tag, "_rsp_gcd"}, g, v.g);
    check({tag, "_rsp_err"}, er, 0);
    check({tag, "_latency"}, rsp_c - rdy_c, v.latency);
    check({tag, "_starts"}, starts, v.starts);
    check({tag, "_rsp_width"}, rsp_valid, 0);
    if (v.starts > 0) begin
      check({tag, "_eng_a"}, sa, v.a);
      check({tag, "_eng_b"}, sb, v.b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gord[5];
    int gexp[5];
    int rcnt[NREQ];
    int rexp[NREQ];
    int gcount, gtotal, ns, s1, s2, dlast, rsp_seen;
    logic [15:0] g1, g2;
    logic [NREQ-1:0] drop;
    int started, bad_rsp, bad_start;

    //            idx  a      b    gcd  lat starts latency
    vecs[0] = '{0,   48,    18,  6,   2,  1,     6};
    vecs[1] = '{2,   0,     35,  35,  1,  0,     3};
    vecs[2] = '{2,   0,     0,   0,   1,  0,     3};
    vecs[3] = '{1,   270,   192, 6,   1,  1,     5};
    vecs[4] = '{3,   17,    0,   17,  1,  0,     3};
    vecs[5] = '{1,   1071,  462, 21,  4,  1,     8};
    vecs[6] = '{3,   65535, 255, 255, 1,  1,     5};

    // reset state with every requester asking
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*16 +: 16] = 16'd9;
      req_b[i*16 +: 16] = 16'd6;
    end
    req_valid = '1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_gcd", rsp_gcd, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_a", eng_a, 0);
    check("rst_eng_b", eng_b, 0);
    check("rst_eng_rst_n", eng_rst_n, 0);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_eng_rst_n", eng_rst_n, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // contention from reset: all four keep requesting
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*16 +: 16] = 16'((i + 1) * 12);
      req_b[i*16 +: 16] = 16'd8;
      rcnt[i] = 0;
    end
    req_valid = '1;
    lat = 1; hold = 1; never = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    gcount = 0; gtotal = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (|req_ready) begin
        if (gcount < 5) gord[gcount] = idx_of(req_ready);
        gcount++;
        gtotal++;
      end
      if (|rsp_valid) rcnt[idx_of(rsp_valid)]++;
      @(posedge clk); #1;
      if (gcount >= 5) req_valid = '0;
    end
    gexp = '{0, 1, 2, 3, 0};
    rexp = '{2, 1, 1, 1};
    check("cont_grants", gtotal, 5);
    for (int i = 0; i < 5; i++) check($sformatf("cont_grant%0d", i), gord[i], gexp[i]);
    for (int i = 0; i < NREQ; i++) check($sformatf("cont_rsp_cnt%0d", i), rcnt[i], rexp[i]);

    // long eng_done with a pending request and a requester that withdraws before grant
    lat = 1; hold = 3;
    for (int i = 0; i < NREQ; i++) rcnt[i] = 0;
    req_a[0 +: 16]  = 16'd100; req_b[0 +: 16]  = 16'd75;
    req_a[16 +: 16] = 16'd84;  req_b[16 +: 16] = 16'd36;
    req_a[48 +: 16] = 16'd5;   req_b[48 +: 16] = 16'd10;
    @(posedge clk); #1;
    req_valid = 4'b0011;
    gcount = 0; ns = 0; s1 = 0; s2 = 0; dlast = 0; rsp_seen = 0; g1 = '0; g2 = '0;
    gord = '{-1, -1, -1, -1, -1};
    for (int c = 0; c < 60; c++) begin
      drop = '0;
      @(negedge clk);
      if (|req_ready) begin
        if (gcount < 5) gord[gcount] = idx_of(req_ready);
        gcount++;
        drop = req_ready;
      end
      if (eng_start) begin
        if (ns == 0) s1 = cyc;
        else if (ns == 1) s2 = cyc;
        ns++;
      end
      if (eng_done && ns == 1) dlast = cyc;
      if (|rsp_valid) begin
        rcnt[idx_of(rsp_valid)]++;
        if (rsp_seen == 0) g1 = rsp_gcd;
        else if (rsp_seen == 1) g2 = rsp_gcd;
        rsp_seen++;
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~drop;
      if (c == 3) req_valid[3] = 1'b1;
      if (c == 5) req_valid[3] = 1'b0;
    end
    check("long_grants", gcount, 2);
    check("long_grant0", gord[0], 1);
    check("long_grant1", gord[1], 0);
    check("long_starts", ns, 2);
    check("long_rsp_cnt1", rcnt[1], 1);
    check("long_rsp_cnt0", rcnt[0], 1);
    check("long_rsp_cnt3", rcnt[3], 0);
    check("long_gcd_first", g1, 12);
    check("long_gcd_second", g2, 25);
    check("long_restart_gap", s2 - dlast, 3);

    // reset pulsed while the engine is busy on 270/192
    lat = 10; hold = 1;
    req_a[16 +: 16] = 16'd270; req_b[16 +: 16] = 16'd192;
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    started = 0;
    for (int c = 0; c < 4; c++) begin
      drop = '0;
      @(negedge clk);
      if (|req_ready) drop = req_ready;
      if (eng_start) started++;
      @(posedge clk); #1;
      req_valid = req_valid & ~drop;
      if (c == 2) check("midrst_busy_eng_a", eng_a, 270);
    end
    check("midrst_started", started, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_gcd", rsp_gcd, 0);
    check("midrst_rsp_err", rsp_err, 0);
    check("midrst_eng_start", eng_start, 0);
    check("midrst_eng_a", eng_a, 0);
    check("midrst_eng_b", eng_b, 0);
    check("midrst_eng_rst_n", eng_rst_n, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad_rsp = 0; bad_start = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (|rsp_valid) bad_rsp++;
      if (eng_start) bad_start++;
    end
    check("midrst_no_rsp", bad_rsp, 0);
    check("midrst_no_start", bad_start, 0);
    run_vec('{1, 270, 192, 6, 1, 1, 5}, "after_rst");

`ifdef GCD_SCHED_TIMEOUT_EN
    begin
      int s, e, lowcnt, r;
      logic er;
      logic [15:0] g;
      logic [NREQ-1:0] rv;
      s = 0; e = 0; lowcnt = 0; r = 0; er = 1'b0; g = 16'hFFFF; rv = '0;
      never = 1'b1;
      req_a[0 +: 16] = 16'd9; req_b[0 +: 16] = 16'd6;
      @(posedge clk); #1;
      req_valid[0] = 1'b1;
      for (int c = 0; c < 60; c++) begin
        drop = '0;
        @(negedge clk);
        if (|req_ready) drop = req_ready;
        if (eng_start) s = cyc;
        if (!eng_rst_n) begin lowcnt++; e = cyc; end
        if (|rsp_valid) begin rv = rsp_valid; er = rsp_err; g = rsp_gcd; r = cyc; end
        @(posedge clk); #1;
        req_valid = req_valid & ~drop;
      end
      never = 1'b0;
      check("to_eng_rst_delay", e - s, 21);
      check("to_eng_rst_width", lowcnt, 1);
      check("to_rsp_valid", rv, 1);
      check("to_rsp_err", er, 1);
      check("to_rsp_gcd", g, 0);
      check("to_rsp_delay", r - s, 23);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
